// File: rtl/pi_gpio_pkg.sv
// pi_gpio_pkg: shared bank encodings, pin count and lane helpers for the Pi header GPIO controller
package pi_gpio_pkg;

    localparam int NUM_PINS    = 28;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        BANK_OUT  = 3'd0,
        BANK_OE   = 3'd1,
        BANK_IN   = 3'd2,
        BANK_PEND = 3'd3,
        BANK_EN   = 3'd4
    } bank_e;

    localparam logic [1:0] LANE_COMMIT = 2'd3;

    // Place a byte into its lane of a 32-bit word.
    function automatic logic [31:0] lane_place(input logic [1:0] lane, input logic [7:0] d);
        return {24'd0, d} << {lane, 3'b000};
    endfunction

endpackage

// File: rtl/pi_gpio_sync.sv
// pi_gpio_sync: N-bit multi-stage input synchroniser with previous-value register and rising-edge detect
//   clk, reset : clock, async active-high reset
//   din        : raw asynchronous inputs
//   sync       : synchronised inputs (last chain stage)
//   rise       : sync & ~prev, one cycle per rising edge
module pi_gpio_sync #(
    parameter int N      = 28,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] din,
    output logic [N-1:0] sync,
    output logic [N-1:0] rise
);

    logic [STAGES-1:0][N-1:0] chain;
    logic [N-1:0]             prev;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            chain <= '0;
            prev  <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end

    assign sync = chain[STAGES-1];
    assign rise = sync & ~prev;

endmodule

// File: rtl/pi_gpio_ctrl.sv
// pi_gpio_ctrl: byte-wide register-mapped controller for the 28-pin Pi header GPIO bus
//   clk, reset              : clock, async active-high reset
//   reg_addr {bank,lane}    : bank 0=OUT 1=OE 2=IN 3=PEND 4=EN
//   reg_wr/reg_rd/reg_wdata : one-cycle access strobes and write data
//   reg_rdata/reg_rvalid    : registered read data and valid pulse, 1 clk after reg_rd
//   gpio_o/gpio_t/gpio_i    : pin outputs, tristate (1 = input), raw pin inputs
//   irq                     : registered |(PEND & EN)
module pi_gpio_ctrl #(
    parameter int NUM_PINS    = pi_gpio_pkg::NUM_PINS,
    parameter int SYNC_STAGES = pi_gpio_pkg::SYNC_STAGES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          reg_addr,
    input  logic                reg_wr,
    input  logic                reg_rd,
    input  logic [7:0]          reg_wdata,
    output logic [7:0]          reg_rdata,
    output logic                reg_rvalid,
    output logic [NUM_PINS-1:0] gpio_o,
    output logic [NUM_PINS-1:0] gpio_t,
    input  logic [NUM_PINS-1:0] gpio_i,
    output logic                irq
);

    import pi_gpio_pkg::*;

    bank_e               bank;
    logic [1:0]          lane;
    logic [NUM_PINS-1:0] out_q, oe_q, pend_q, en_q, sync, rise, pend_clr;
    logic [23:0]         out_sh, oe_sh;
    logic [31:0]         wplace, wmask, rd_word;
    logic                wr_out, wr_oe, commit;

    assign bank     = bank_e'(reg_addr[4:2]);
    assign lane     = reg_addr[1:0];
    assign wplace   = lane_place(lane, reg_wdata);
    assign wmask    = lane_place(lane, 8'hFF);
    assign wr_out   = reg_wr && bank == BANK_OUT;
    assign wr_oe    = reg_wr && bank == BANK_OE;
    assign commit   = lane == LANE_COMMIT;
    assign pend_clr = (reg_wr && bank == BANK_PEND) ? NUM_PINS'(wplace) : '0;

    pi_gpio_sync #(.N(NUM_PINS), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (gpio_i),
        .sync  (sync),
        .rise  (rise)
    );

    // Lanes 0-2 stage into a shadow; lane 3 commits the whole word atomically.
    // Truncating {wdata, shadow} to NUM_PINS drops lane 3 bits [7:4].
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            out_q  <= '0;
            oe_q   <= '0;
            out_sh <= '0;
            oe_sh  <= '0;
        end else begin
            if (wr_out && commit)
                out_q <= NUM_PINS'({reg_wdata, out_sh});
            else if (wr_out)
                out_sh <= (out_sh & ~wmask[23:0]) | wplace[23:0];
            if (wr_oe && commit)
                oe_q <= NUM_PINS'({reg_wdata, oe_sh});
            else if (wr_oe)
                oe_sh <= (oe_sh & ~wmask[23:0]) | wplace[23:0];
        end

    // Set is OR-ed in after the clear so a same-cycle rise survives a W1C.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            en_q   <= '0;
            pend_q <= '0;
            irq    <= 1'b0;
        end else begin
            if (reg_wr && bank == BANK_EN)
                en_q <= (en_q & ~NUM_PINS'(wmask)) | NUM_PINS'(wplace);
            pend_q <= (pend_q & ~pend_clr) | (rise & en_q);
            irq    <= |(pend_q & en_q);
        end

    always_comb begin
        rd_word = '0;
        case (bank)
            BANK_OUT:  rd_word = 32'(out_q);
            BANK_OE:   rd_word = 32'(oe_q);
            BANK_IN:   rd_word = 32'(sync);
            BANK_PEND: rd_word = 32'(pend_q);
            BANK_EN:   rd_word = 32'(en_q);
            default:   rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            reg_rdata  <= '0;
            reg_rvalid <= 1'b0;
        end else begin
            reg_rvalid <= reg_rd;
            if (reg_rd)
                reg_rdata <= rd_word[{lane, 3'b000} +: 8];
        end

    assign gpio_o = out_q;
    assign gpio_t = ~oe_q;

endmodule

// File: tb/tb_pi_gpio_ctrl.sv
// tb_pi_gpio_ctrl: directed self-checking bench for pi_gpio_ctrl
module tb_pi_gpio_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  reg_addr = '0;
    logic        reg_wr = 1'b0;
    logic        reg_rd = 1'b0;
    logic [7:0]  reg_wdata = '0;
    logic [7:0]  reg_rdata;
    logic        reg_rvalid;
    logic [27:0] gpio_o, gpio_t;
    logic [27:0] gpio_i = '0;
    logic        irq;
    int          n_chk = 0;
    int          n_fail = 0;

    localparam logic [4:0] A_OUT0 = 5'd0, A_OUT1 = 5'd1, A_OUT2 = 5'd2, A_OUT3 = 5'd3;
    localparam logic [4:0] A_OE0 = 5'd4, A_OE1 = 5'd5, A_OE2 = 5'd6, A_OE3 = 5'd7;
    localparam logic [4:0] A_IN2 = 5'd10, A_PEND0 = 5'd12, A_PEND2 = 5'd14, A_EN0 = 5'd16;

    pi_gpio_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .reg_addr   (reg_addr),
        .reg_wr     (reg_wr),
        .reg_rd     (reg_rd),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .reg_rvalid (reg_rvalid),
        .gpio_o     (gpio_o),
        .gpio_t     (gpio_t),
        .gpio_i     (gpio_i),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_wr    = 1'b1;
        @(posedge clk);
        #1 reg_wr = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [7:0] exp);
        reg_addr = a;
        reg_rd   = 1'b1;
        @(posedge clk);
        #1 reg_rd = 1'b0;
        check({tag, "_rvalid"}, 32'(reg_rvalid), 32'd1);
        check(tag, 32'(reg_rdata), 32'(exp));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tick(2);
        check("rst_gpio_o", 32'(gpio_o), 32'h0);
        check("rst_gpio_t", 32'(gpio_t), 32'h0FFF_FFFF);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_rvalid", 32'(reg_rvalid), 32'h0);
        check("rst_rdata", 32'(reg_rdata), 32'h0);
        reset = 1'b0;
        tick(1);

        wr(A_OUT0, 8'hAA);
        wr(A_OUT1, 8'h55);
        wr(A_OUT2, 8'hF0);
        check("out_staged", 32'(gpio_o), 32'h0);
        wr(A_OUT3, 8'hF7);
        check("out_commit", 32'(gpio_o), 32'h07F0_55AA);
        rd("rd_out3", A_OUT3, 8'h07);
        tick(1);
        check("rvalid_drop", 32'(reg_rvalid), 32'h0);
        rd("rd_out0", A_OUT0, 8'hAA);
        wr(A_OUT3, 8'h01);
        check("out_recommit", 32'(gpio_o), 32'h01F0_55AA);

        wr(A_OE0, 8'h0C);
        check("oe_staged", 32'(gpio_t), 32'h0FFF_FFFF);
        wr(A_OE1, 8'h00);
        wr(A_OE2, 8'h00);
        wr(A_OE3, 8'hF0);
        check("oe_commit", 32'(gpio_t), 32'h0FFF_FFF3);
        rd("rd_oe3", A_OE3, 8'h00);
        rd("rd_oe0", A_OE0, 8'h0C);
        rd("rd_unmapped", 5'd20, 8'h00);

        gpio_i[20] = 1'b1;
        rd("in_plus1", A_IN2, 8'h00);
        tick(1);
        rd("in_plus3", A_IN2, 8'h10);
        rd("pend_masked", A_PEND2, 8'h00);

        wr(A_EN0, 8'h01);
        gpio_i[0] = 1'b1;
        tick(4);
        check("edge_irq", 32'(irq), 32'h1);
        rd("edge_pend", A_PEND0, 8'h01);
        wr(A_PEND0, 8'h01);
        tick(1);
        check("w1c_irq", 32'(irq), 32'h0);
        rd("w1c_pend", A_PEND0, 8'h00);
        gpio_i[0] = 1'b0;
        tick(4);
        rd("fall_pend", A_PEND0, 8'h00);
        check("fall_irq", 32'(irq), 32'h0);

        reg_addr  = A_EN0;
        reg_wdata = 8'h03;
        reg_wr    = 1'b1;
        reg_rd    = 1'b1;
        @(posedge clk);
        #1 reg_wr = 1'b0;
        reg_rd = 1'b0;
        check("rw_old", 32'(reg_rdata), 32'h01);
        rd("rw_new", A_EN0, 8'h03);
        wr(A_EN0, 8'h01);

        gpio_i[0] = 1'b1;
        tick(2);
        wr(A_PEND0, 8'h01);
        rd("coll_pend", A_PEND0, 8'h01);
        check("coll_irq", 32'(irq), 32'h1);
        wr(A_EN0, 8'h00);
        rd("en_off_pend", A_PEND0, 8'h01);
        check("en_off_irq", 32'(irq), 32'h0);
        wr(A_EN0, 8'h01);
        tick(1);
        check("en_on_irq", 32'(irq), 32'h1);

        wr(A_OUT0, 8'h12);
        #2 reset = 1'b1;
        #1;
        check("arst_gpio_t", 32'(gpio_t), 32'h0FFF_FFFF);
        check("arst_gpio_o", 32'(gpio_o), 32'h0);
        check("arst_irq", 32'(irq), 32'h0);
        #5 reset = 1'b0;
        tick(1);
        wr(A_OUT3, 8'h00);
        check("arst_shadow", 32'(gpio_o), 32'h0);
        rd("arst_oe0", A_OE0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
